// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decode fields, resolves operands with
// EX/MEM forwarding, and inserts a one-cycle bubble on load-use hazards.
module id_ex_stage #(
  parameter int OP_W   = 4,
  parameter int SEL_W  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              stall_in,
  input  logic              id_valid,
  input  logic [OP_W-1:0]   id_aluop,
  input  logic [SEL_W-1:0]  id_alusel,
  input  logic [DATA_W-1:0] id_left_imm,
  input  logic [DATA_W-1:0] id_right_imm,
  input  logic              id_left_re,
  input  logic              id_right_re,
  input  logic [ADDR_W-1:0] id_left_addr,
  input  logic [ADDR_W-1:0] id_right_addr,
  input  logic [DATA_W-1:0] id_left_rf,
  input  logic [DATA_W-1:0] id_right_rf,
  input  logic              id_wreg,
  input  logic [ADDR_W-1:0] id_waddr,
  input  logic              id_is_load,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_wreg,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              ex_valid,
  output logic [OP_W-1:0]   ex_aluop,
  output logic [SEL_W-1:0]  ex_alusel,
  output logic [DATA_W-1:0] ex_srcLeft,
  output logic [DATA_W-1:0] ex_srcRight,
  output logic              ex_wreg,
  output logic [ADDR_W-1:0] ex_waddr,
  output logic              ex_is_load,
  output logic              stall_req,
  output logic [31:0]       stat_bubbles
);

  logic [DATA_W-1:0] left_res, right_res;
  logic              ex_fwd_ok, hazard;

  // A load in EX has no result yet, so it is never an EX forward source.
  assign ex_fwd_ok = ex_valid & ex_wreg & ~ex_is_load;

  always_comb begin
    left_res = id_left_rf;
    if (!id_left_re)                                  left_res = id_left_imm;
    else if (id_left_addr == '0)                      left_res = '0;
    else if (ex_fwd_ok && ex_waddr == id_left_addr)   left_res = ex_result;
    else if (mem_wreg && mem_waddr == id_left_addr)   left_res = mem_wdata;
  end

  always_comb begin
    right_res = id_right_rf;
    if (!id_right_re)                                 right_res = id_right_imm;
    else if (id_right_addr == '0)                     right_res = '0;
    else if (ex_fwd_ok && ex_waddr == id_right_addr)  right_res = ex_result;
    else if (mem_wreg && mem_waddr == id_right_addr)  right_res = mem_wdata;
  end

  always_comb begin
    hazard = id_valid & ex_valid & ex_is_load & (ex_waddr != '0) &
             ((id_left_re  & (id_left_addr  == ex_waddr)) |
              (id_right_re & (id_right_addr == ex_waddr)));
  end

  assign stall_req = hazard & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_aluop     <= '0;
      ex_alusel    <= '0;
      ex_srcLeft   <= '0;
      ex_srcRight  <= '0;
      ex_wreg      <= 1'b0;
      ex_waddr     <= '0;
      ex_is_load   <= 1'b0;
      stat_bubbles <= '0;
    end else if (flush || (!stall_in && hazard)) begin
      ex_valid    <= 1'b0;
      ex_aluop    <= '0;
      ex_alusel   <= '0;
      ex_srcLeft  <= '0;
      ex_srcRight <= '0;
      ex_wreg     <= 1'b0;
      ex_waddr    <= '0;
      ex_is_load  <= 1'b0;
      if (!flush && stat_bubbles != '1)
        stat_bubbles <= stat_bubbles + 32'd1;
    end else if (!stall_in) begin
      ex_valid    <= id_valid;
      ex_aluop    <= id_aluop;
      ex_alusel   <= id_valid ? id_alusel : '0;
      ex_srcLeft  <= left_res;
      ex_srcRight <= right_res;
      ex_wreg     <= id_valid & id_wreg;
      ex_waddr    <= id_waddr;
      ex_is_load  <= id_valid & id_is_load;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized checks of id_ex_stage against a cycle-level
// reference model of the EX slot held in the bench.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, stall_in, id_valid;
  logic [3:0]  id_aluop, id_alusel;
  logic [31:0] id_left_imm, id_right_imm, id_left_rf, id_right_rf;
  logic        id_left_re, id_right_re, id_wreg, id_is_load, mem_wreg;
  logic [4:0]  id_left_addr, id_right_addr, id_waddr, mem_waddr;
  logic [31:0] ex_result, mem_wdata;
  logic        ex_valid, ex_wreg, ex_is_load, stall_req;
  logic [3:0]  ex_aluop, ex_alusel;
  logic [31:0] ex_srcLeft, ex_srcRight, stat_bubbles;
  logic [4:0]  ex_waddr;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model of the EX slot
  logic        m_valid, m_wreg, m_load, m_known;
  logic [3:0]  m_aluop, m_sel;
  logic [31:0] m_l, m_r, m_stat;
  logic [4:0]  m_waddr;

  id_ex_stage #(.OP_W(4), .SEL_W(4), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall_in(stall_in),
    .id_valid(id_valid), .id_aluop(id_aluop), .id_alusel(id_alusel),
    .id_left_imm(id_left_imm), .id_right_imm(id_right_imm),
    .id_left_re(id_left_re), .id_right_re(id_right_re),
    .id_left_addr(id_left_addr), .id_right_addr(id_right_addr),
    .id_left_rf(id_left_rf), .id_right_rf(id_right_rf),
    .id_wreg(id_wreg), .id_waddr(id_waddr), .id_is_load(id_is_load),
    .ex_result(ex_result), .mem_wreg(mem_wreg), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .ex_valid(ex_valid), .ex_aluop(ex_aluop),
    .ex_alusel(ex_alusel), .ex_srcLeft(ex_srcLeft), .ex_srcRight(ex_srcRight),
    .ex_wreg(ex_wreg), .ex_waddr(ex_waddr), .ex_is_load(ex_is_load),
    .stall_req(stall_req), .stat_bubbles(stat_bubbles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_res(input logic re, input logic [4:0] a,
                                        input logic [31:0] imm, input logic [31:0] rf);
    if (!re) return imm;
    if (a == 5'd0) return 32'd0;
    if (m_valid && m_wreg && !m_load && m_waddr == a) return ex_result;
    if (mem_wreg && mem_waddr == a) return mem_wdata;
    return rf;
  endfunction

  task automatic m_reset();
    m_valid = 0; m_wreg = 0; m_load = 0; m_known = 1;
    m_aluop = '0; m_sel = '0; m_l = '0; m_r = '0; m_waddr = '0; m_stat = '0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 32'(ex_valid), 32'(m_valid));
    chk({tag, ".sel"},   32'(ex_alusel), 32'(m_sel));
    chk({tag, ".wreg"},  32'(ex_wreg), 32'(m_wreg));
    chk({tag, ".load"},  32'(ex_is_load), 32'(m_load));
    chk({tag, ".stat"},  stat_bubbles, m_stat);
    if (m_known) begin
      chk({tag, ".aluop"}, 32'(ex_aluop), 32'(m_aluop));
      chk({tag, ".left"},  ex_srcLeft, m_l);
      chk({tag, ".right"}, ex_srcRight, m_r);
      chk({tag, ".waddr"}, 32'(ex_waddr), 32'(m_waddr));
    end
  endtask

  // One clock: check stall_req against the model, clock, advance model, check.
  task automatic cycle(input string tag);
    logic hz;
    logic [31:0] nl, nr;
    #1;
    hz = id_valid && m_valid && m_load && m_waddr != 0 &&
         ((id_left_re && id_left_addr == m_waddr) || (id_right_re && id_right_addr == m_waddr));
    chk({tag, ".stall_req"}, 32'(stall_req), 32'(hz && !flush));
    nl = m_res(id_left_re, id_left_addr, id_left_imm, id_left_rf);
    nr = m_res(id_right_re, id_right_addr, id_right_imm, id_right_rf);
    @(posedge clk);
    if (flush) begin
      m_valid = 0; m_wreg = 0; m_load = 0; m_sel = '0;
      m_aluop = '0; m_l = '0; m_r = '0; m_waddr = '0; m_known = 1;
    end else if (stall_in) begin
      // hold
    end else if (hz) begin
      m_valid = 0; m_wreg = 0; m_load = 0; m_sel = '0; m_known = 0;
      if (m_stat != 32'hFFFF_FFFF) m_stat = m_stat + 1;
    end else begin
      m_valid = id_valid; m_aluop = id_aluop;
      m_sel = id_valid ? id_alusel : 4'd0;
      m_wreg = id_valid & id_wreg; m_load = id_valid & id_is_load;
      m_waddr = id_waddr; m_l = nl; m_r = nr; m_known = 1;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_inputs();
    flush = 0; stall_in = 0; id_valid = 0; id_aluop = '0; id_alusel = '0;
    id_left_imm = '0; id_right_imm = '0; id_left_re = 0; id_right_re = 0;
    id_left_addr = '0; id_right_addr = '0; id_left_rf = '0; id_right_rf = '0;
    id_wreg = 0; id_waddr = '0; id_is_load = 0; ex_result = '0;
    mem_wreg = 0; mem_waddr = '0; mem_wdata = '0;
  endtask

  task automatic issue(input logic [4:0] wa, input logic ld);
    idle_inputs();
    id_valid = 1; id_aluop = 4'h2; id_alusel = 4'b0010; id_wreg = 1;
    id_waddr = wa; id_is_load = ld;
  endtask

  logic [31:0] snap_l, snap_r;

  initial begin
    idle_inputs();
    rst_n = 0;
    m_reset();
    #12;
    check_outputs("reset");
    chk("reset.stall_req", 32'(stall_req), 32'd0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // 1: reset then capture with immediates
    idle_inputs();
    id_valid = 1; id_aluop = 4'h1; id_alusel = 4'b0001;
    id_left_imm = 32'h0F0F0000; id_right_imm = 32'h00FF00FF;
    cycle("t1");
    chk("t1.left_const", ex_srcLeft, 32'h0F0F0000);
    chk("t1.right_const", ex_srcRight, 32'h00FF00FF);
    chk("t1.valid_const", 32'(ex_valid), 32'd1);

    // 2: EX forward beats MEM forward; then MEM forward when EX invalid
    issue(5'd5, 0); cycle("t2a");
    idle_inputs(); id_valid = 1; id_alusel = 4'b0001; id_left_re = 1; id_left_addr = 5'd5;
    id_left_rf = 32'h33333333; ex_result = 32'h11111111;
    mem_wreg = 1; mem_waddr = 5'd5; mem_wdata = 32'h22222222;
    cycle("t2b");
    chk("t2.exfwd", ex_srcLeft, 32'h11111111);
    issue(5'd5, 0); id_valid = 0; cycle("t2c");
    idle_inputs(); id_valid = 1; id_alusel = 4'b0001; id_left_re = 1; id_left_addr = 5'd5;
    id_left_rf = 32'h33333333; ex_result = 32'h11111111;
    mem_wreg = 1; mem_waddr = 5'd5; mem_wdata = 32'h22222222;
    cycle("t2d");
    chk("t2.memfwd", ex_srcLeft, 32'h22222222);

    // 3: r0 always reads zero
    issue(5'd0, 0); cycle("t3a");
    idle_inputs(); id_valid = 1; id_left_re = 1; id_right_re = 1;
    id_left_rf = 32'hDEADBEEF; id_right_rf = 32'hDEADBEEF; ex_result = 32'h5555AAAA;
    mem_wreg = 1; mem_waddr = 5'd0; mem_wdata = 32'h77777777;
    cycle("t3b");
    chk("t3.r0left", ex_srcLeft, 32'd0);
    chk("t3.r0right", ex_srcRight, 32'd0);

    // 4: load-use bubble, then MEM forward of the load result
    issue(5'd3, 1); cycle("t4a");
    idle_inputs(); id_valid = 1; id_alusel = 4'b0100; id_right_re = 1;
    id_right_addr = 5'd3; id_right_rf = 32'hBAD0BAD0;
    #1 chk("t4.stall_on", 32'(stall_req), 32'd1);
    cycle("t4b");
    chk("t4.bubble_valid", 32'(ex_valid), 32'd0);
    chk("t4.bubble_sel", 32'(ex_alusel), 32'd0);
    chk("t4.bubble_cnt", stat_bubbles, 32'd1);
    chk("t4.stall_off", 32'(stall_req), 32'd0);
    mem_wreg = 1; mem_waddr = 5'd3; mem_wdata = 32'h00000042;
    cycle("t4c");
    chk("t4.memfwd", ex_srcRight, 32'h00000042);

    // 5: flush beats stall; then stall alone holds for 3 cycles
    issue(5'd7, 1); cycle("t5a");
    idle_inputs(); id_valid = 1; id_left_re = 1; id_left_addr = 5'd7;
    flush = 1; stall_in = 1;
    cycle("t5b");
    chk("t5.flush_valid", 32'(ex_valid), 32'd0);
    chk("t5.flush_stall", 32'(stall_req), 32'd0);
    issue(5'd9, 0); id_left_imm = 32'hCAFE0001; id_right_imm = 32'h0000BEEF; cycle("t5c");
    snap_l = ex_srcLeft; snap_r = ex_srcRight;
    idle_inputs(); stall_in = 1; id_valid = 1; id_left_imm = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      cycle("t5hold");
      chk("t5.hold_left", ex_srcLeft, 32'hCAFE0001);
      chk("t5.hold_right", ex_srcRight, 32'h0000BEEF);
      chk("t5.hold_valid", 32'(ex_valid), 32'd1);
    end

    // 6: async reset during a bubble
    issue(5'd4, 1); cycle("t6a");
    idle_inputs(); id_valid = 1; id_left_re = 1; id_left_addr = 5'd4;
    cycle("t6b");
    @(negedge clk); #2 rst_n = 0;
    m_reset();
    #1;
    check_outputs("t6.async");
    chk("t6.async_cnt", stat_bubbles, 32'd0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    idle_inputs();

    // Randomized traffic with small register numbers to provoke hazards
    for (int i = 0; i < 400; i++) begin
      flush = ($urandom_range(0, 9) == 0);
      stall_in = ($urandom_range(0, 6) == 0);
      id_valid = ($urandom_range(0, 4) != 0);
      id_aluop = 4'($urandom); id_alusel = 4'(1 << $urandom_range(0, 3));
      id_left_imm = $urandom; id_right_imm = $urandom;
      id_left_rf = $urandom; id_right_rf = $urandom;
      id_left_re = 1'($urandom); id_right_re = 1'($urandom);
      id_left_addr = 5'($urandom_range(0, 3)); id_right_addr = 5'($urandom_range(0, 3));
      id_wreg = 1'($urandom); id_waddr = 5'($urandom_range(0, 3));
      id_is_load = ($urandom_range(0, 2) == 0);
      ex_result = $urandom;
      mem_wreg = 1'($urandom); mem_waddr = 5'($urandom_range(0, 3)); mem_wdata = $urandom;
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode and execute. Captures the decoded ALU op, the unit select and both operands.
- Resolves read-after-write hazards by forwarding from the EX and MEM stages. Forwarded values are folded into the captured operands.
- Detects load-use hazards, raises a stall request and inserts a one-cycle bubble.
- Its registered outputs drive the logic, arithmetic and shift ALUs directly.

Parameters:
- OP_W, 4, width of the low ALU op field driven to EX.
- SEL_W, 4, width of the one-hot ALU unit select.
- ADDR_W, 5, register address width.
- DATA_W, 32, operand/word width.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  kill the captured instruction (branch/exception).
- stall_in  in  1  downstream stall: hold all EX registers.
- id_valid  in  1  decode slot holds a real instruction.
- id_aluop  in  OP_W  decoded ALU op.
- id_alusel  in  SEL_W  one-hot ALU unit select.
- id_left_imm / id_right_imm  in  DATA_W  non-register operand values.
- id_left_re / id_right_re  in  1  operand comes from the register file.
- id_left_addr / id_right_addr  in  ADDR_W  source register numbers.
- id_left_rf / id_right_rf  in  DATA_W  register-file read data.
- id_wreg  in  1  instruction writes a register.
- id_waddr  in  ADDR_W  destination register.
- id_is_load  in  1  instruction is a load.
- ex_result  in  DATA_W  combinational result of the instruction currently in EX.
- mem_wreg  in  1  MEM stage will write a register.
- mem_waddr  in  ADDR_W  MEM stage destination register.
- mem_wdata  in  DATA_W  MEM stage write data.
- ex_valid  out  1  EX slot valid.
- ex_aluop  out  OP_W  to ALU op input.
- ex_alusel  out  SEL_W  to ALU enables.
- ex_srcLeft / ex_srcRight  out  DATA_W  resolved operands.
- ex_wreg  out  1  registered destination write enable.
- ex_waddr  out  ADDR_W  registered destination register.
- ex_is_load  out  1  registered load flag.
- stall_req  out  1  combinational request to freeze PC/IF/ID.
- stat_bubbles  out  32  saturating count of inserted load-use bubbles.

Interface decision:
- One clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst_n=0, asynchronous): all ex_* outputs are 0 and stat_bubbles=0.
- Operand resolution (combinational, per side):
  - If re=0: use the imm input.
  - Else if addr==0: use 0.
  - Else if ex_valid & ex_wreg & !ex_is_load & ex_waddr==addr: use ex_result.
  - Else if mem_wreg & mem_waddr==addr: use mem_wdata.
  - Else: use the rf input.
  - EX forwarding has priority over MEM forwarding.
- Load-use hazard:
  - hazard = id_valid & ex_valid & ex_is_load & ex_waddr!=0 & ((id_left_re & id_left_addr==ex_waddr) | (id_right_re & id_right_addr==ex_waddr)).
  - stall_req = hazard & !flush.
- Register update at posedge clk, priority order:
  1. flush=1: ex_valid, ex_wreg, ex_is_load and ex_alusel go to 0; other fields are don't-care (cleared to 0). flush wins over stall_in and hazard.
  2. stall_in=1: every EX register holds its value. No bubble is counted. stall_req is still driven from hazard.
  3. hazard=1: insert a bubble. ex_valid, ex_wreg, ex_is_load and ex_alusel go to 0, and stat_bubbles increments, saturating at 0xFFFFFFFF.
  4. Otherwise: capture ex_valid=id_valid together with the resolved operands and the decode fields.
- When id_valid=0 is captured, ex_wreg, ex_is_load and ex_alusel are forced to 0, so the ALUs output zero.
- Latency: exactly one cycle from decode to EX. The bubble lasts exactly one cycle.
- The load result reaches the second instruction through the MEM forward path in the cycle after the bubble.
- During hold, resolution is recomputed every cycle. ID is frozen upstream, so a new MEM write seen during the hold is picked up.
- rst_n asserted mid-stall or mid-bubble: the outputs clear immediately; no pending state survives.

Test Plan:
1. Reset then capture: rst_n 0→1; id_valid=1, aluop=AND, alusel=LOGIC, left_imm=0x0F0F0000, right_imm=0x00FF00FF, re=0. Next cycle: ex_srcLeft=0x0F0F0000, ex_srcRight=0x00FF00FF, ex_valid=1.
2. EX forward priority: EX holds a non-load write of r5 with ex_result=0x11111111; MEM writes r5 with 0x22222222; ID reads r5 on the left. Captured ex_srcLeft=0x11111111. Repeat with the EX instruction invalid: captured ex_srcLeft=0x22222222.
3. Register 0: ID reads r0 with rf=0xDEADBEEF while EX and MEM both write r0 with nonzero values. Captured operand=0.
4. Load-use: EX holds a load to r3; ID reads r3 on the right. stall_req=1 for exactly one cycle. The next EX holds a bubble (ex_valid=0, alusel=0) and stat_bubbles=1. In the following cycle, with mem_wdata=0x00000042, ex_srcRight=0x00000042.
5. Flush beats stall: assert flush and stall_in together with a valid instruction in EX. Next cycle ex_valid=0 and stall_req=0. With stall_in alone, all outputs hold for 3 cycles unchanged.
6. Async reset mid-bubble: drop rst_n between clock edges during a load-use bubble. ex_* and stat_bubbles clear without waiting for a clock edge.
